rle_encoder: RTL and testbench

Run-length encoder producing the 16-bit RLE word stream consumed by the VGA RLE playback path. Accepts one 6-bit colour per pixel beat with frame-start and end-of-stream markers, and merges equal consecutive pixels into runs. Emits `{run[9:0], colour[5:0]}` words over a valid/ready interface toward the flash/PSRAM image writer, then a terminator word. Runs never span frames, because playback discards any remaining run at each frame boundary.

---
 rtl/rle_pkg.sv | 30 +++
 rtl/rle_encoder.sv | 124 ++++++++++++
 tb/tb_rle_encoder.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rle_pkg.sv
// Shared RLE word format used by the encoder and by the VGA playback path.
// The word is {run[9:0], colour[5:0]}; run 0x3ff is reserved for the terminator.
package rle_pkg;

  localparam int unsigned RUN_W    = 10;
  localparam int unsigned COLOUR_W = 6;

  localparam logic [RUN_W-1:0] RLE_TERM_RUN  = 10'h3ff;
  localparam logic [15:0]      RLE_TERM_WORD = 16'hFFC0;

  typedef struct packed {
    logic [RUN_W-1:0]    run;
    logic [COLOUR_W-1:0] colour;
  } rle_word_t;

  typedef enum logic [1:0] {
    IDLE_RUN,
    FLUSH,
    TERM
  } rle_state_e;

  function automatic rle_word_t rle_pack(input logic [RUN_W-1:0]    run,
                                         input logic [COLOUR_W-1:0] colour);
    rle_word_t w;
    w.run    = run;
    w.colour = colour;
    return w;
  endfunction

endpackage

// File: rtl/rle_encoder.sv
// Run-length encoder: merges equal consecutive pixels into {run, colour} words,
// never spanning a frame boundary, and closes each stream with a terminator word.
module rle_encoder
  import rle_pkg::*;
#(
  parameter int unsigned MAX_RUN = 1022
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_colour,
  input  logic        in_frame_start,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_word,
  output logic        busy,
  output logic [15:0] word_count
);

  localparam logic [RUN_W-1:0] MAX_RUN_L = RUN_W'(MAX_RUN);

  rle_state_e          state_q, state_d;
  logic                open_q, open_d;
  logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
  logic [COLOUR_W-1:0] run_col_q, run_col_d;
  logic                out_valid_q, out_valid_d;
  rle_word_t           out_word_q, out_word_d;
  logic [15:0]         word_count_q, word_count_d;

  logic out_free;
  logic accept;
  logic close_run;
  logic load;

  always_comb begin
    out_free  = !out_valid_q || out_ready;
    in_ready  = out_free && (state_q == IDLE_RUN);
    accept    = in_valid && in_ready;
    close_run = open_q && ((in_colour != run_col_q) || in_frame_start ||
                           (run_cnt_q == MAX_RUN_L));

    state_d      = state_q;
    open_d       = open_q;
    run_cnt_d    = run_cnt_q;
    run_col_d    = run_col_q;
    out_word_d   = out_word_q;
    word_count_d = word_count_q;
    load         = 1'b0;
    // A taken word frees the register; a load below in the same cycle re-arms it.
    out_valid_d  = out_valid_q && !out_ready;

    unique case (state_q)
      IDLE_RUN: begin
        if (accept) begin
          if (close_run) begin
            load       = 1'b1;
            out_word_d = rle_pack(run_cnt_q, run_col_q);
          end
          if (!open_q || close_run) begin
            open_d    = 1'b1;
            run_cnt_d = RUN_W'(1);
            run_col_d = in_colour;
          end else begin
            run_cnt_d = run_cnt_q + 1'b1;
          end
          if (in_last) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          if (open_q) begin
            load       = 1'b1;
            out_word_d = rle_pack(run_cnt_q, run_col_q);
          end
          open_d  = 1'b0;
          state_d = TERM;
        end
      end
      TERM: begin
        if (out_free) begin
          load       = 1'b1;
          out_word_d = rle_pack(RLE_TERM_RUN, '0);
          state_d    = IDLE_RUN;
        end
      end
      default: state_d = IDLE_RUN;
    endcase

    if (load) begin
      out_valid_d  = 1'b1;
      word_count_d = word_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE_RUN;
      open_q       <= 1'b0;
      run_cnt_q    <= '0;
      run_col_q    <= '0;
      out_valid_q  <= 1'b0;
      out_word_q   <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      open_q       <= open_d;
      run_cnt_q    <= run_cnt_d;
      run_col_q    <= run_col_d;
      out_valid_q  <= out_valid_d;
      out_word_q   <= out_word_d;
      word_count_q <= word_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_word   = out_word_q;
  assign word_count = word_count_q;
  assign busy       = open_q || (state_q != IDLE_RUN);

endmodule

// File: tb/tb_rle_encoder.sv
// Randomized self-checking bench for rle_encoder against a run-grouping reference model.
module tb_rle_encoder;

  localparam int unsigned MAX_RUN = 1022;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_colour = '0;
  logic        in_frame_start = 1'b0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_word;
  logic        busy;
  logic [15:0] word_count;

  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned rdy_mode = 0;
  int unsigned total_words = 0;

  typedef struct {
    logic [5:0] col;
    logic       fs;
  } beat_t;

  beat_t       stim[$];
  logic [15:0] obs_q[$];
  int unsigned obs_cyc[$];
  logic [15:0] exp_q[$];

  rle_encoder #(.MAX_RUN(MAX_RUN)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_colour     (in_colour),
    .in_frame_start(in_frame_start),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_word      (out_word),
    .busy          (busy),
    .word_count    (word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Downstream ready: 0 = always, 1 = random 50%, 2 = held low
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom % 2);
      default: out_ready = 1'b0;
    endcase
  end

  // Output monitor: collects handshaken words and checks stability while stalled.
  logic        prev_stall = 1'b0;
  logic [15:0] prev_word = '0;
  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_stable", 32'(out_word), 32'(prev_word));
      end
      if (out_valid && out_ready) begin
        obs_q.push_back(out_word);
        obs_cyc.push_back(cyc);
        total_words++;
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = out_word;
    end
  end

  // Reference: group the beat list into maximal runs, split at frame starts and MAX_RUN.
  function automatic void build_exp();
    int unsigned i = 0;
    int unsigned j;
    exp_q.delete();
    while (i < stim.size()) begin
      j = i + 1;
      while (j < stim.size() && stim[j].col == stim[i].col && !stim[j].fs && (j - i) < MAX_RUN)
        j++;
      exp_q.push_back({10'(j - i), stim[i].col});
      i = j;
    end
    exp_q.push_back(16'hFFC0);
  endfunction

  task automatic send_beat(input logic [5:0] col, input logic fs, input logic last);
    int unsigned w = 0;
    bit done = 1'b0;
    in_colour      = col;
    in_frame_start = fs;
    in_last        = last;
    in_valid       = 1'b1;
    while (!done && w < 2000) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
      w++;
    end
    in_valid       = 1'b0;
    in_last        = 1'b0;
    in_frame_start = 1'b0;
    check("beat_accepted", 32'(done), 32'd1);
  endtask

  task automatic do_stream(input string tag);
    int unsigned w = 0;
    int unsigned npix = 0;
    int unsigned bad = 32'hFFFF_FFFF;
    int unsigned bad_runs = 0;
    int unsigned n;
    logic [9:0] run;
    obs_q.delete();
    obs_cyc.delete();
    foreach (stim[i]) begin
      send_beat(stim[i].col, stim[i].fs, i == stim.size() - 1);
      if (rdy_mode == 1 && $urandom % 4 == 0)
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
    end
    while (!(obs_q.size() > 0 && obs_q[obs_q.size()-1] == 16'hFFC0) && w < 20000) begin
      @(negedge clk);
      #1;
      w++;
    end
    check({tag, " terminator_seen"}, 32'(w < 20000), 32'd1);
    build_exp();
    check({tag, " n_words"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int unsigned i = 0; i < n; i++)
      check($sformatf("%s word%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    // Decode the observed words back to pixels and compare with the input stream.
    for (int unsigned k = 0; k + 1 < obs_q.size(); k++) begin
      run = obs_q[k][15:6];
      if (run == 10'd0 || run == 10'h3ff) bad_runs++;
      for (int unsigned r = 0; r < run; r++) begin
        if (bad == 32'hFFFF_FFFF && (npix >= stim.size() || stim[npix].col != obs_q[k][5:0]))
          bad = npix;
        npix++;
      end
    end
    check({tag, " decode_len"}, npix, stim.size());
    check({tag, " decode_first_bad"}, bad, 32'hFFFF_FFFF);
    check({tag, " reserved_runs"}, bad_runs, 0);
    @(negedge clk);
    check({tag, " drained_valid"}, 32'(out_valid), 32'd0);
    check({tag, " drained_busy"}, 32'(busy), 32'd0);
    check({tag, " word_count"}, 32'(word_count), 32'(total_words[15:0]));
    @(posedge clk);
    #1;
  endtask

  task automatic check_words(input string tag, input int unsigned cnt,
                             input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3);
    logic [15:0] lit[4];
    lit[0] = w0; lit[1] = w1; lit[2] = w2; lit[3] = w3;
    check({tag, " lit_count"}, obs_q.size(), cnt);
    for (int unsigned i = 0; i < cnt && i < obs_q.size(); i++)
      check($sformatf("%s lit%0d", tag, i), 32'(obs_q[i]), 32'(lit[i]));
  endtask

  task automatic push_beats(input int unsigned cnt, input logic [5:0] col, input logic fs_first);
    for (int unsigned i = 0; i < cnt; i++)
      stim.push_back('{col: col, fs: (i == 0) ? fs_first : 1'b0});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned remaining;
    int unsigned n;
    logic [5:0]  c;
    logic [5:0]  prev;

    rdy_mode = 0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_word", 32'(out_word), 32'd0);
    check("rst word_count", 32'(word_count), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    stim.delete();
    push_beats(5, 6'h2A, 1'b1);
    do_stream("t1");
    check_words("t1", 2, 16'h016A, 16'hFFC0, 16'h0, 16'h0);
    check("t1 word_count_abs", 32'(word_count), 32'd2);

    stim.delete();
    push_beats(2, 6'h01, 1'b0);
    push_beats(1, 6'h02, 1'b0);
    push_beats(3, 6'h03, 1'b0);
    do_stream("t2");
    check_words("t2", 4, 16'h0081, 16'h0042, 16'h00C3, 16'hFFC0);

    stim.delete();
    push_beats(1025, 6'h01, 1'b0);
    do_stream("t3_maxrun");
    check_words("t3_maxrun", 3, 16'hFF81, 16'h00C1, 16'hFFC0, 16'h0);

    stim.delete();
    push_beats(3, 6'h00, 1'b0);
    push_beats(2, 6'h00, 1'b1);
    do_stream("t4_frame");
    check_words("t4_frame", 3, 16'h00C0, 16'h0080, 16'hFFC0, 16'h0);

    // Last beat closing a run: three words on consecutive cycles.
    stim.delete();
    push_beats(2, 6'h05, 1'b0);
    push_beats(1, 6'h07, 1'b0);
    do_stream("t5_b2b");
    check_words("t5_b2b", 3, 16'h0085, 16'h0047, 16'hFFC0, 16'h0);
    check("t5_b2b cycle_span",
          (obs_cyc.size() >= 3) ? obs_cyc[2] - obs_cyc[0] : 32'd0, 32'd2);

    rdy_mode = 1;
    remaining = 10000;
    prev = '0;
    while (remaining > 0) begin
      n = $urandom_range(1, 1500);
      if (n > remaining) n = remaining;
      stim.delete();
      for (int unsigned i = 0; i < n; i++) begin
        if (i > 0 && $urandom % 10 < 7) c = prev;
        else if ($urandom % 5 == 0) c = 6'($urandom);
        else c = 6'($urandom % 4);
        stim.push_back('{col: c, fs: ($urandom % 33 == 0)});
        prev = c;
      end
      do_stream("rand");
      remaining -= n;
    end

    // Reset while FLUSH is pending with downstream stalled.
    rdy_mode = 2;
    @(posedge clk);
    #1;
    send_beat(6'h01, 1'b1, 1'b0);
    send_beat(6'h02, 1'b0, 1'b1);
    check("pre_rst busy", 32'(busy), 32'd1);
    check("pre_rst out_valid", 32'(out_valid), 32'd1);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    total_words = 0;
    @(negedge clk);
    check("mid_rst out_valid", 32'(out_valid), 32'd0);
    check("mid_rst busy", 32'(busy), 32'd0);
    check("mid_rst word_count", 32'(word_count), 32'd0);
    check("mid_rst in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rdy_mode = 0;
    @(posedge clk);
    #1;

    stim.delete();
    push_beats(4, 6'h3F, 1'b1);
    push_beats(1, 6'h10, 1'b0);
    do_stream("post_rst");
    check_words("post_rst", 3, 16'h013F, 16'h0050, 16'hFFC0, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
